config_loader: RTL and testbench

//  Upstream feeder of the tile config bus. Receives a framed byte stream (valid/ready) and

---
 rtl/config_loader_pkg.sv | 41 ++++
 rtl/config_loader_if.sv | 33 +++
 rtl/config_word_assembler.sv | 46 ++++
 rtl/config_loader.sv | 193 +++++++++++++++++++
 tb/tb_config_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
//   Shared definitions for the tile configuration loader:
//     - section ids decoded by the pe_tile blocks in config_addr[31:16]
//     - frame header byte and parked bus address
//     - FSM state encoding plus decode helpers for the registered
//       byte_ready / busy outputs
// -----------------------------------------------------------------------------
package config_loader_pkg;

    localparam logic [15:0] CFG_SEC_CLB   = 16'd4;
    localparam logic [15:0] CFG_SEC_CB1   = 16'd5;
    localparam logic [15:0] CFG_SEC_CB0   = 16'd6;
    localparam logic [15:0] CFG_SEC_SB    = 16'd7;

    localparam logic [7:0]  CFG_HEADER    = 8'hA5;
    localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // States in which the loader takes stream bytes.
    function automatic logic ready_in(input state_t s);
        return (s == ST_IDLE) || (s == ST_CNT_HI) || (s == ST_CNT_LO) ||
               (s == ST_PAYLOAD) || (s == ST_CHECK);
    endfunction

    // A frame is in progress everywhere except the resting states.
    function automatic logic busy_in(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR));
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// -----------------------------------------------------------------------------
// config_loader_if
//   Groups the byte stream (valid/ready) and the broadcast config write bus.
//     byte_data   [7:0]   stream byte              (master -> slave)
//     byte_valid          stream byte valid        (master -> slave)
//     byte_ready          loader accepts the byte  (slave  -> master)
//     config_addr [31:0]  {section, tile_id}, parked when idle (slave -> master)
//     config_data [31:0]  write payload, 0 when idle           (slave -> master)
//   master: the stream source / bus observer.  slave: the loader.
// -----------------------------------------------------------------------------
interface config_loader_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  config_addr,
        input  config_data
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output config_addr,
        output config_data
    );
endinterface

// File: rtl/config_word_assembler.sv
// -----------------------------------------------------------------------------
// config_word_assembler
//   Collects eight stream bytes (MSB first) into one 64-bit {addr,data} word.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset (clears the index)
//     shift_en     accept byte_in this cycle
//     clear        restart the byte index at 0 (frame start)
//     byte_in      incoming byte
//     word         {previous 7 bytes, byte_in}; complete when load_done=1
//     load_done    byte_in is the 8th byte of the word
// -----------------------------------------------------------------------------
module config_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [63:0] word,
    output logic        load_done
);

    logic [55:0] shreg;
    logic [2:0]  idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= 3'd0;
        end else if (clear) begin
            idx <= 3'd0;
        end else if (shift_en) begin
            idx <= idx + 3'd1;
        end
    end

    // Only the last seven bytes are stored; the eighth is used straight from
    // the input so the finished word is available on the accepting edge.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {shreg[47:0], byte_in};
        end
    end

    assign word      = {shreg, byte_in};
    assign load_done = shift_en && (idx == 3'd7);

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//   Receives a framed byte stream and turns each 8-byte payload word into one
//   single-cycle write on config_addr/config_data, broadcast to all pe_tiles.
//   Frame: HEADER, N[15:8], N[7:0], N x {addr[31:0], data[31:0]} MSB first,
//   then an XOR checksum byte when CONFIG_LOADER_CHECKSUM_EN is defined.
//   Optional feature macro: CONFIG_LOADER_CHECKSUM_EN (checksum byte + error).
//   Ports:
//     clk            clock
//     reset          asynchronous active-low reset
//     start          re-arm pulse, honoured in DONE/ERROR only
//     bus            config_loader_if.slave (byte stream + config write bus)
//     busy           frame in progress
//     done           sticky, frame completed cleanly
//     error          sticky, checksum mismatch (0 without the macro)
//     words_written  writes issued in the current/last frame
// -----------------------------------------------------------------------------
module config_loader
    import config_loader_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR = CFG_IDLE_ADDR,
    parameter logic [7:0]  HEADER    = CFG_HEADER,
    parameter int          COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    config_loader_if.slave     bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] words_written
);

    state_t             state;
    logic               ready_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic [7:0]         cnt_hi;
    logic [COUNT_W-1:0] word_count;
    logic [COUNT_W-1:0] ww_next;

    logic               accept;
    logic               shift_en;
    logic               asm_clear;
    logic               load_done;
    logic [63:0]        asm_word;

    assign accept    = bus.byte_valid && ready_q;
    assign shift_en  = accept && (state == ST_PAYLOAD);
    assign asm_clear = (state == ST_CNT_HI) || (state == ST_CNT_LO);
    assign ww_next   = words_written + 1'b1;

    assign bus.byte_ready  = ready_q;
    assign bus.config_addr = addr_q;
    assign bus.config_data = data_q;

    config_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en),
        .clear     (asm_clear),
        .byte_in   (bus.byte_data),
        .word      (asm_word),
        .load_done (load_done)
    );

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       error_q;
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // Move to a new state and update the registered handshake/status outputs
    // so they are valid in the first cycle of that state.
    task automatic go(input state_t nxt);
        state   <= nxt;
        ready_q <= ready_in(nxt);
        busy    <= busy_in(nxt);
    endtask

    // Entered when the last word has been issued (or N was zero).
    task automatic end_payload();
`ifdef CONFIG_LOADER_CHECKSUM_EN
        go(ST_CHECK);
`else
        done <= 1'b1;
        go(ST_DONE);
`endif
    endtask

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            ready_q       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            addr_q        <= IDLE_ADDR;
            data_q        <= 32'd0;
            cnt_hi        <= 8'd0;
            word_count    <= '0;
            words_written <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            csum          <= 8'd0;
            error_q       <= 1'b0;
`endif
        end else begin
            // Bus parks unless a write is being launched this edge; outputs
            // track the current state unless a transition overrides them.
            addr_q  <= IDLE_ADDR;
            data_q  <= 32'd0;
            ready_q <= ready_in(state);
            busy    <= busy_in(state);

            case (state)
                ST_IDLE: begin
                    if (accept && (bus.byte_data == HEADER)) begin
                        go(ST_CNT_HI);
                    end
                end
                ST_CNT_HI: begin
                    if (accept) begin
                        cnt_hi        <= bus.byte_data;
                        words_written <= '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum          <= 8'd0;
`endif
                        go(ST_CNT_LO);
                    end
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        word_count    <= COUNT_W'({cnt_hi, bus.byte_data});
                        words_written <= '0;
                        if ({cnt_hi, bus.byte_data} == 16'd0) begin
                            end_payload();
                        end else begin
                            go(ST_PAYLOAD);
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.byte_data;
`endif
                        if (load_done) begin
                            addr_q <= asm_word[63:32];
                            data_q <= asm_word[31:0];
                            go(ST_ISSUE);
                        end
                    end
                end
                ST_ISSUE: begin
                    words_written <= ww_next;
                    if (ww_next == word_count) begin
                        end_payload();
                    end else begin
                        go(ST_PAYLOAD);
                    end
                end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (bus.byte_data == csum) begin
                            done <= 1'b1;
                            go(ST_DONE);
                        end else begin
                            error_q <= 1'b1;
                            go(ST_ERROR);
                        end
                    end
                end
`endif
                ST_DONE, ST_ERROR: begin
                    if (start) begin
                        done <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        error_q <= 1'b0;
`endif
                        go(ST_IDLE);
                    end
                end
                default: begin
                    go(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//   Drives framed byte streams into config_loader and checks every config bus
//   write against words queued by the stimulus, plus end-of-frame status.
// -----------------------------------------------------------------------------
module tb_config_loader;
    import config_loader_pkg::*;

    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    config_loader_if bus();

    config_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_q[$];
    bit          gaps = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: any non-parked address is a write; it must match the oldest
    // word the stimulus has completed, and no byte may be taken that cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.config_addr !== IDLE) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.config_addr), 64'(IDLE));
                end else begin
                    check("write_word", {bus.config_addr, bus.config_data}, exp_q.pop_front());
                    check("ready_low_in_issue", 64'(bus.byte_ready), 64'd0);
                end
            end else if (bus.config_data !== 32'd0) begin
                check("idle_data_zero", 64'(bus.config_data), 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int t;
        bit got;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        t = 0;
        do begin
            got = bus.byte_ready;
            @(posedge clk); #1;
            t++;
        end while (!got && t < 100);
        if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
        bus.byte_valid = 1'b0;
    endtask

    // Sends a frame; a word is queued as expected once its 8th byte is taken.
    task automatic send_frame(input logic [63:0] words[$], input bit bad_csum);
        logic [7:0] cs;
        logic [7:0] b;
        int         n;
        cs = 8'd0;
        n  = words.size();
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (words[i]) begin
            for (int j = 0; j < 8; j++) begin
                b  = words[i][63-8*j -: 8];
                cs = cs ^ b;
                send_byte(b);
            end
            exp_q.push_back(words[i]);
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~cs : cs);
`else
        if (bad_csum) cs = ~cs;
`endif
    endtask

    task automatic finish_frame(input string tag, input bit exp_err, input int exp_n);
        int t;
        t = 0;
        while (!(done || error) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check({tag, "_end_timeout"}, 64'd0, 64'd1);
        @(negedge clk); #1;
        check({tag, "_done"}, 64'(done), exp_err ? 64'd0 : 64'd1);
        check({tag, "_error"}, 64'(error), exp_err ? 64'd1 : 64'd0);
        check({tag, "_words_written"}, 64'(words_written), 64'(exp_n));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        start = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        @(posedge clk); #1;
        start = 1'b0;
        bus.byte_valid = 1'b0;
        check({tag, "_done_cleared"}, 64'(done), 64'd0);
        check({tag, "_error_cleared"}, 64'(error), 64'd0);
        check({tag, "_count_kept"}, 64'(words_written), 64'(exp_n));
        check({tag, "_idle_after_start"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] rand_word();
        logic [15:0] sec;
        sec = 16'(4 + $urandom_range(0, 3));
        return {sec, 16'($urandom), 32'($urandom)};
    endfunction

    logic [63:0] w[$];
    bit          bad;

    initial begin
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 64'(bus.config_addr), 64'(IDLE));
        check("rst_data", 64'(bus.config_data), 64'd0);
        check("rst_ready", 64'(bus.byte_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        reset = 1'b1;
        #1;
        check("ready_before_first_clk", 64'(bus.byte_ready), 64'd0);
        @(posedge clk); #1;
        check("ready_after_first_clk", 64'(bus.byte_ready), 64'd1);

        // Single known word
        w = {64'h0004_0003_0000_0002};
        send_frame(w, 1'b0);
        finish_frame("t1", 1'b0, 1);

        // Empty frame
        w = {};
        send_frame(w, 1'b0);
        finish_frame("t2", 1'b0, 0);

        // Leading garbage bytes are dropped
        send_byte(8'h11);
        send_byte(8'h22);
        w = {rand_word()};
        send_frame(w, 1'b0);
        finish_frame("t3", 1'b0, 1);

        // Reset in the middle of a payload word
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        for (int j = 0; j < 5; j++) send_byte(8'($urandom));
        reset = 1'b0;
        #1;
        check("t4_bus_parked", 64'(bus.config_addr), 64'(IDLE));
        check("t4_ready_low", 64'(bus.byte_ready), 64'd0);
        check("t4_busy_low", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        w = {rand_word()};
        send_frame(w, 1'b0);
        finish_frame("t4", 1'b0, 1);

`ifdef CONFIG_LOADER_CHECKSUM_EN
        // Wrong checksum: writes stay issued, error flagged
        w = {rand_word(), rand_word()};
        send_frame(w, 1'b1);
        finish_frame("t5", 1'b1, 2);
`endif

        // Random frames, with and without gaps in byte_valid
        for (int f = 0; f < 8; f++) begin
            gaps = (f % 2) == 1;
            w = {};
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) w.push_back(rand_word());
`ifdef CONFIG_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`else
            bad = 1'b0;
`endif
            send_frame(w, bad);
            finish_frame("rand", bad, w.size());
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
